aux_req_arbiter: RTL and testbench
==================================

Name: aux_req_arbiter

Overview:
- Shares the single AUX CTRL unit request port between three link-training requesters: LPM native accesses, CR FSM and EQ FSM.
- Each requester's single-cycle transaction request is latched into a one-deep pending slot.
- One owner is granted at a time and its request is issued to AUX CTRL as a one-cycle valid pulse.
- The block waits for ack, native-failed or timeout, routes that response only to the owner, then releases the port.

Parameters:
- TIMEOUT_CYC, 1023: WAIT-state cycles without an AUX CTRL response before a forced failure. Legal range 2..65535.
- TO_W, 16: timeout counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lpm_transaction_vld, cr_transaction_vld, eq_transaction_vld  in  1 each  single-cycle request pulse from each requester
- lpm_cmd, cr_cmd, eq_cmd  in  2 each  AUX command
- lpm_address, cr_address, eq_address  in  20 each  DPCD/I2C address
- lpm_len, cr_len, eq_len  in  8 each  length field, passed through unchanged
- lpm_data, cr_data, eq_data  in  8 each  write data byte
- ctrl_ack_flag  in  1  AUX CTRL transaction acknowledged
- ctrl_native_failed  in  1  AUX CTRL transaction failed
- ctrl_transaction_vld  out  1  one-cycle issue pulse to AUX CTRL
- ctrl_cmd  out  2  command of the issued request
- ctrl_address  out  20  address of the issued request
- ctrl_len  out  8  length of the issued request
- ctrl_data  out  8  data byte of the issued request
- lpm_ack_flag, cr_ack_flag, eq_ack_flag  out  1 each  routed ack pulse
- lpm_native_failed, cr_native_failed, eq_native_failed  out  1 each  routed failure pulse
- arb_busy  out  1  port owned (state other than IDLE)
- arb_owner  out  2  current owner: 0 = LPM, 1 = CR, 2 = EQ, 3 = none
- timeout_err  out  1  one-cycle pulse when a timeout fires
- req_ovf  out  3  one-cycle pulse per requester, bit0 = LPM, bit1 = CR, bit2 = EQ; request dropped

Behaviour:
- Reset: all outputs 0 except arb_owner = 3. Pending slots empty, state IDLE, timeout counter 0, round-robin pointer at LPM.
- Pending slot per requester:
  - vld sampled high with slot empty: {cmd, address, len, data} is captured and the slot is marked pending at that edge.
  - vld high while the slot is already pending (queued or in flight): request dropped, req_ovf[i] pulses the next cycle, stored fields untouched.
  - vld high in the same cycle as the slot's release: the new request is accepted; set wins over clear.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any slot is pending, select the winner (see arbitration), load arb_owner, go to ISSUE.
  - ISSUE: ctrl_transaction_vld = 1 for exactly this cycle. ctrl_cmd/address/len/data are driven from the owner's slot and held stable through WAIT. Clear the counter and go to WAIT.
  - WAIT, ctrl_native_failed = 1: owner's native_failed pulses next cycle. Failed wins when ack and failed are both high.
  - WAIT, ctrl_ack_flag = 1 (failed low): owner's ack_flag pulses next cycle.
  - WAIT, counter reaches TIMEOUT_CYC-1 with no response: owner's native_failed and timeout_err pulse next cycle.
  - WAIT, on any of the three exits: clear the owner's slot, set arb_owner = 3, return to IDLE. Otherwise increment the counter.
- ctrl_ack_flag and ctrl_native_failed are ignored in IDLE and ISSUE.
- Arbitration: fixed priority LPM > CR > EQ, unless the optional feature is enabled.
- Latency: request vld at cycle N gives ctrl_transaction_vld at cycle N+2 when the port is idle. A response at cycle M gives the routed pulse at M+1, and the next ctrl_transaction_vld is no earlier than M+2.
- ctrl_* payload outputs are all registered. Routed pulses reach only the owner; non-owners stay 0.
- Reset mid-transaction: immediate return to the reset state. Pending requests are lost and no response pulse is generated.

Optional Feature:
- Macro: AUX_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at the requester after the last granted one (order LPM, CR, EQ, wrapping). The pointer updates on every grant.
- Undefined: fixed priority LPM > CR > EQ, no pointer logic.

Test Plan:
- Single CR request: cr vld with cmd=2'b00, addr=20'h00103, len=8'd0, data=8'h0A at cycle 0 -> ctrl_transaction_vld at cycle 2 with the same fields. ack at cycle 6 -> cr_ack_flag at cycle 7; arb_owner 1 -> 3, arb_busy low at 7.
- Simultaneous requests: LPM, CR and EQ vld all at cycle 0, each acked 3 cycles after issue.
  - Fixed priority -> grants LPM, CR, EQ.
  - With AUX_ARB_RR_EN and last grant = CR -> grants EQ, LPM, CR.
- Ack and failed high in the same WAIT cycle for an EQ owner -> eq_native_failed = 1, eq_ack_flag = 0, no pulse to LPM or CR.
- TIMEOUT_CYC=8, no response -> eq_native_failed and timeout_err pulse 8 cycles after WAIT entry; slot cleared; a later EQ request issues normally.
- CR vld again while its request is in WAIT -> req_ovf = 3'b010 for one cycle, ctrl_address unchanged. CR vld in the release cycle -> accepted and issued 2 cycles later.
- rst_n low during WAIT with an LPM request pending -> all outputs return to reset values immediately; after release no lpm_ack_flag and no issue occur.

Source files
------------

// File: rtl/aux_req_arbiter.sv
// aux_req_arbiter
//   Shares the single AUX CTRL request port between three link-training
//   requesters (LPM native, CR FSM, EQ FSM). Each requester has a one-deep
//   pending slot. One owner at a time is issued to AUX CTRL as a one-cycle
//   valid pulse. The ack, failure or timeout response is routed back to the
//   owner only, and then the port is released.
//
//   Build option: define AUX_ARB_RR_EN for round-robin arbitration.
//   Without it, arbitration is fixed priority LPM > CR > EQ.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   {lpm,cr,eq}_*           request pulse and payload {cmd, address, len, data}
//   ctrl_ack_flag           AUX CTRL ack input
//   ctrl_native_failed      AUX CTRL failure input
//   ctrl_*                  registered issue pulse and payload to AUX CTRL
//   {lpm,cr,eq}_ack_flag    routed ack pulses
//   {lpm,cr,eq}_native_failed routed failure pulses
//   arb_busy                high while the port is owned
//   arb_owner               current owner (0 LPM, 1 CR, 2 EQ, 3 none)
//   timeout_err             one-cycle pulse when no response arrives in time
//   req_ovf                 per-requester pulse when a request is dropped
module aux_req_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned TO_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lpm_transaction_vld,
    input  logic        cr_transaction_vld,
    input  logic        eq_transaction_vld,
    input  logic [1:0]  lpm_cmd,
    input  logic [1:0]  cr_cmd,
    input  logic [1:0]  eq_cmd,
    input  logic [19:0] lpm_address,
    input  logic [19:0] cr_address,
    input  logic [19:0] eq_address,
    input  logic [7:0]  lpm_len,
    input  logic [7:0]  cr_len,
    input  logic [7:0]  eq_len,
    input  logic [7:0]  lpm_data,
    input  logic [7:0]  cr_data,
    input  logic [7:0]  eq_data,
    input  logic        ctrl_ack_flag,
    input  logic        ctrl_native_failed,
    output logic        ctrl_transaction_vld,
    output logic [1:0]  ctrl_cmd,
    output logic [19:0] ctrl_address,
    output logic [7:0]  ctrl_len,
    output logic [7:0]  ctrl_data,
    output logic        lpm_ack_flag,
    output logic        cr_ack_flag,
    output logic        eq_ack_flag,
    output logic        lpm_native_failed,
    output logic        cr_native_failed,
    output logic        eq_native_failed,
    output logic        arb_busy,
    output logic [1:0]  arb_owner,
    output logic        timeout_err,
    output logic [2:0]  req_ovf
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    localparam logic [1:0]      OwnerNone = 2'd3;
    localparam logic [TO_W-1:0] CntLast   = TO_W'(TIMEOUT_CYC - 1);

    // Payload packing: {cmd[37:36], address[35:16], len[15:8], data[7:0]}
    logic [2:0]       req_vld;
    logic [2:0][37:0] req_in;

    assign req_vld   = {eq_transaction_vld, cr_transaction_vld, lpm_transaction_vld};
    assign req_in[0] = {lpm_cmd, lpm_address, lpm_len, lpm_data};
    assign req_in[1] = {cr_cmd, cr_address, cr_len, cr_data};
    assign req_in[2] = {eq_cmd, eq_address, eq_len, eq_data};

    logic [1:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0][37:0] slot_q, slot_d;
    logic [37:0]      payload_q, payload_d;
    logic             issue_q, issue_d;
    logic [2:0]       ack_q, ack_d;
    logic [2:0]       fail_q, fail_d;
    logic             to_q, to_d;
    logic [2:0]       ovf_q, ovf_d;
    logic [2:0]       owner_oh;
    logic [2:0]       rel;
    logic [1:0]       win;

`ifdef AUX_ARB_RR_EN
    // Index of the requester the next search starts from.
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        win = 2'd0;
        unique case (ptr_q)
            2'd1:    win = pend_q[1] ? 2'd1 : (pend_q[2] ? 2'd2 : 2'd0);
            2'd2:    win = pend_q[2] ? 2'd2 : (pend_q[0] ? 2'd0 : 2'd1);
            default: win = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
        endcase
    end
`else
    always_comb begin
        win = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
    end
`endif

    always_comb begin
        owner_oh = 3'b000;
        unique case (owner_q)
            2'd0:    owner_oh = 3'b001;
            2'd1:    owner_oh = 3'b010;
            2'd2:    owner_oh = 3'b100;
            default: owner_oh = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        slot_d    = slot_q;
        payload_d = payload_q;
        issue_d   = 1'b0;
        ack_d     = 3'b000;
        fail_d    = 3'b000;
        to_d      = 1'b0;
        ovf_d     = 3'b000;
        rel       = 3'b000;
`ifdef AUX_ARB_RR_EN
        ptr_d     = ptr_q;
`endif

        case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    owner_d   = win;
                    payload_d = slot_q[win];
                    issue_d   = 1'b1;
                    state_d   = StIssue;
`ifdef AUX_ARB_RR_EN
                    ptr_d     = (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (ctrl_native_failed) begin
                    fail_d = owner_oh;
                    rel    = owner_oh;
                end else if (ctrl_ack_flag) begin
                    ack_d = owner_oh;
                    rel   = owner_oh;
                end else if (cnt_q == CntLast) begin
                    fail_d = owner_oh;
                    to_d   = 1'b1;
                    rel    = owner_oh;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
                if (|rel) begin
                    owner_d = OwnerNone;
                    state_d = StIdle;
                end
            end
            default: begin
                owner_d = OwnerNone;
                state_d = StIdle;
            end
        endcase

        // A new request in the release cycle wins over the clear.
        for (int i = 0; i < 3; i++) begin
            if (req_vld[i] && (!pend_q[i] || rel[i])) begin
                pend_d[i] = 1'b1;
                slot_d[i] = req_in[i];
            end else if (req_vld[i]) begin
                ovf_d[i] = 1'b1;
            end else if (rel[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= OwnerNone;
            cnt_q     <= '0;
            pend_q    <= 3'b000;
            slot_q    <= '0;
            payload_q <= '0;
            issue_q   <= 1'b0;
            ack_q     <= 3'b000;
            fail_q    <= 3'b000;
            to_q      <= 1'b0;
            ovf_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            slot_q    <= slot_d;
            payload_q <= payload_d;
            issue_q   <= issue_d;
            ack_q     <= ack_d;
            fail_q    <= fail_d;
            to_q      <= to_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef AUX_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign ctrl_transaction_vld = issue_q;
    assign ctrl_cmd             = payload_q[37:36];
    assign ctrl_address         = payload_q[35:16];
    assign ctrl_len             = payload_q[15:8];
    assign ctrl_data            = payload_q[7:0];
    assign lpm_ack_flag         = ack_q[0];
    assign cr_ack_flag          = ack_q[1];
    assign eq_ack_flag          = ack_q[2];
    assign lpm_native_failed    = fail_q[0];
    assign cr_native_failed     = fail_q[1];
    assign eq_native_failed     = fail_q[2];
    assign arb_busy             = (state_q != StIdle);
    assign arb_owner            = owner_q;
    assign timeout_err          = to_q;
    assign req_ovf              = ovf_q;

endmodule

// File: tb/tb_aux_req_arbiter.sv
// Directed bench for aux_req_arbiter with TIMEOUT_CYC = 8.
// "Cycle" = the interval starting 1 time unit after a rising clock edge;
// inputs are driven and outputs sampled there.
module tb_aux_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lpm_transaction_vld = 1'b0, cr_transaction_vld = 1'b0, eq_transaction_vld = 1'b0;
    logic [1:0]  lpm_cmd = '0, cr_cmd = '0, eq_cmd = '0;
    logic [19:0] lpm_address = '0, cr_address = '0, eq_address = '0;
    logic [7:0]  lpm_len = '0, cr_len = '0, eq_len = '0;
    logic [7:0]  lpm_data = '0, cr_data = '0, eq_data = '0;
    logic        ctrl_ack_flag = 1'b0, ctrl_native_failed = 1'b0;
    logic        ctrl_transaction_vld;
    logic [1:0]  ctrl_cmd;
    logic [19:0] ctrl_address;
    logic [7:0]  ctrl_len, ctrl_data;
    logic        lpm_ack_flag, cr_ack_flag, eq_ack_flag;
    logic        lpm_native_failed, cr_native_failed, eq_native_failed;
    logic        arb_busy, timeout_err;
    logic [1:0]  arb_owner;
    logic [2:0]  req_ovf;

    int n_vec = 0;
    int n_err = 0;

    aux_req_arbiter #(
        .TIMEOUT_CYC(8),
        .TO_W       (16)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .lpm_transaction_vld (lpm_transaction_vld),
        .cr_transaction_vld  (cr_transaction_vld),
        .eq_transaction_vld  (eq_transaction_vld),
        .lpm_cmd             (lpm_cmd),
        .cr_cmd              (cr_cmd),
        .eq_cmd              (eq_cmd),
        .lpm_address         (lpm_address),
        .cr_address          (cr_address),
        .eq_address          (eq_address),
        .lpm_len             (lpm_len),
        .cr_len              (cr_len),
        .eq_len              (eq_len),
        .lpm_data            (lpm_data),
        .cr_data             (cr_data),
        .eq_data             (eq_data),
        .ctrl_ack_flag       (ctrl_ack_flag),
        .ctrl_native_failed  (ctrl_native_failed),
        .ctrl_transaction_vld(ctrl_transaction_vld),
        .ctrl_cmd            (ctrl_cmd),
        .ctrl_address        (ctrl_address),
        .ctrl_len            (ctrl_len),
        .ctrl_data           (ctrl_data),
        .lpm_ack_flag        (lpm_ack_flag),
        .cr_ack_flag         (cr_ack_flag),
        .eq_ack_flag         (eq_ack_flag),
        .lpm_native_failed   (lpm_native_failed),
        .cr_native_failed    (cr_native_failed),
        .eq_native_failed    (eq_native_failed),
        .arb_busy            (arb_busy),
        .arb_owner           (arb_owner),
        .timeout_err         (timeout_err),
        .req_ovf             (req_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // who: 0 LPM, 1 CR, 2 EQ
    task automatic set_req(input int who, input logic [1:0] cmd, input logic [19:0] addr,
                           input logic [7:0] len, input logic [7:0] data);
        case (who)
            0: begin
                lpm_transaction_vld = 1'b1; lpm_cmd = cmd; lpm_address = addr;
                lpm_len = len; lpm_data = data;
            end
            1: begin
                cr_transaction_vld = 1'b1; cr_cmd = cmd; cr_address = addr;
                cr_len = len; cr_data = data;
            end
            default: begin
                eq_transaction_vld = 1'b1; eq_cmd = cmd; eq_address = addr;
                eq_len = len; eq_data = data;
            end
        endcase
    endtask

    task automatic clr_req();
        lpm_transaction_vld = 1'b0;
        cr_transaction_vld  = 1'b0;
        eq_transaction_vld  = 1'b0;
    endtask

    // Advance until the issue pulse is seen, bounded to 20 cycles.
    task automatic wait_issue(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (ctrl_transaction_vld) break;
            cyc(1);
        end
        check_val(tag, ctrl_transaction_vld, 1);
    endtask

    initial begin
        int exp_own[3];
        logic [19:0] exp_adr[3];
        logic saw_issue;
        logic saw_ack;

`ifdef AUX_ARB_RR_EN
        exp_own = '{2, 0, 1};
`else
        exp_own = '{0, 1, 2};
`endif
        exp_adr = '{20'h00200, 20'h00300, 20'h00400};

        // Reset state
        #12;
        check_val("rst_owner", arb_owner, 3);
        check_val("rst_busy", arb_busy, 0);
        check_val("rst_ctrl_vld", ctrl_transaction_vld, 0);
        check_val("rst_addr", ctrl_address, 0);
        check_val("rst_ovf", req_ovf, 0);
        check_val("rst_to", timeout_err, 0);
        rst_n = 1'b1;
        cyc(2);

        // Single CR request (cycle 0 here)
        set_req(1, 2'b00, 20'h00103, 8'd0, 8'h0A);
        cyc(1);
        clr_req();
        check_val("cr_c1_vld", ctrl_transaction_vld, 0);
        cyc(1);
        check_val("cr_c2_vld", ctrl_transaction_vld, 1);
        check_val("cr_c2_addr", ctrl_address, 20'h00103);
        check_val("cr_c2_cmd", ctrl_cmd, 0);
        check_val("cr_c2_len", ctrl_len, 0);
        check_val("cr_c2_data", ctrl_data, 8'h0A);
        check_val("cr_c2_owner", arb_owner, 1);
        check_val("cr_c2_busy", arb_busy, 1);
        cyc(1);
        check_val("cr_c3_vld", ctrl_transaction_vld, 0);
        check_val("cr_c3_addr", ctrl_address, 20'h00103);
        cyc(3);
        ctrl_ack_flag = 1'b1;
        cyc(1);
        ctrl_ack_flag = 1'b0;
        check_val("cr_c7_ack", {eq_ack_flag, cr_ack_flag, lpm_ack_flag}, 3'b010);
        check_val("cr_c7_owner", arb_owner, 3);
        check_val("cr_c7_busy", arb_busy, 0);
        cyc(1);
        check_val("cr_c8_ack", cr_ack_flag, 0);

        // Simultaneous requests
        set_req(0, 2'b01, exp_adr[0], 8'd1, 8'h11);
        set_req(1, 2'b10, exp_adr[1], 8'd2, 8'h22);
        set_req(2, 2'b11, exp_adr[2], 8'd3, 8'h33);
        cyc(1);
        clr_req();
        for (int g = 0; g < 3; g++) begin
            wait_issue($sformatf("sim_issue%0d", g));
            check_val($sformatf("sim_owner%0d", g), arb_owner, exp_own[g]);
            check_val($sformatf("sim_addr%0d", g), ctrl_address, exp_adr[exp_own[g]]);
            cyc(3);
            ctrl_ack_flag = 1'b1;
            cyc(1);
            ctrl_ack_flag = 1'b0;
            check_val($sformatf("sim_ack%0d", g), {eq_ack_flag, cr_ack_flag, lpm_ack_flag},
                      3'b001 << exp_own[g]);
        end
        cyc(2);

        // Ack and failed together for an EQ owner
        set_req(2, 2'b01, 20'h00500, 8'd4, 8'h44);
        cyc(1);
        clr_req();
        wait_issue("both_issue");
        cyc(2);
        ctrl_ack_flag = 1'b1;
        ctrl_native_failed = 1'b1;
        cyc(1);
        ctrl_ack_flag = 1'b0;
        ctrl_native_failed = 1'b0;
        check_val("both_nf", {eq_native_failed, cr_native_failed, lpm_native_failed}, 3'b100);
        check_val("both_ack", {eq_ack_flag, cr_ack_flag, lpm_ack_flag}, 3'b000);
        check_val("both_to", timeout_err, 0);
        cyc(2);

        // Timeout with TIMEOUT_CYC = 8: WAIT entry is issue+1, pulse at issue+9
        set_req(2, 2'b00, 20'h00600, 8'd5, 8'h55);
        cyc(1);
        clr_req();
        wait_issue("to_issue");
        cyc(8);
        check_val("to_early_nf", eq_native_failed, 0);
        check_val("to_early_busy", arb_busy, 1);
        cyc(1);
        check_val("to_nf", eq_native_failed, 1);
        check_val("to_err", timeout_err, 1);
        check_val("to_owner", arb_owner, 3);
        cyc(1);
        check_val("to_err_off", timeout_err, 0);
        set_req(2, 2'b00, 20'h00601, 8'd5, 8'h56);
        cyc(1);
        clr_req();
        wait_issue("to_reissue");
        check_val("to_reissue_addr", ctrl_address, 20'h00601);
        cyc(2);
        ctrl_ack_flag = 1'b1;
        cyc(1);
        ctrl_ack_flag = 1'b0;
        check_val("to_reissue_ack", eq_ack_flag, 1);
        cyc(2);

        // CR overflow while in WAIT, then re-request in the release cycle
        set_req(1, 2'b00, 20'h00700, 8'd6, 8'h66);
        cyc(1);
        clr_req();
        wait_issue("ovf_issue");
        cyc(1);
        set_req(1, 2'b01, 20'h00777, 8'd7, 8'h77);
        cyc(1);
        clr_req();
        check_val("ovf_pulse", req_ovf, 3'b010);
        check_val("ovf_addr", ctrl_address, 20'h00700);
        cyc(1);
        check_val("ovf_off", req_ovf, 3'b000);
        cyc(1);
        ctrl_ack_flag = 1'b1;
        set_req(1, 2'b10, 20'h00789, 8'd8, 8'h88);
        cyc(1);
        ctrl_ack_flag = 1'b0;
        clr_req();
        check_val("rel_ack", cr_ack_flag, 1);
        check_val("rel_ovf", req_ovf, 3'b000);
        check_val("rel_c1_vld", ctrl_transaction_vld, 0);
        cyc(1);
        check_val("rel_c2_vld", ctrl_transaction_vld, 1);
        check_val("rel_c2_addr", ctrl_address, 20'h00789);
        cyc(2);
        ctrl_ack_flag = 1'b1;
        cyc(1);
        ctrl_ack_flag = 1'b0;
        cyc(2);

        // Reset during WAIT with an LPM request in flight
        set_req(0, 2'b01, 20'h00900, 8'd9, 8'h99);
        cyc(1);
        clr_req();
        wait_issue("rst_issue");
        cyc(1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", arb_busy, 0);
        check_val("mid_rst_owner", arb_owner, 3);
        check_val("mid_rst_addr", ctrl_address, 0);
        #5;
        rst_n = 1'b1;
        saw_issue = 1'b0;
        saw_ack = 1'b0;
        ctrl_ack_flag = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            ctrl_ack_flag = 1'b0;
            saw_issue |= ctrl_transaction_vld;
            saw_ack |= lpm_ack_flag;
        end
        check_val("post_rst_issue", saw_issue, 0);
        check_val("post_rst_ack", saw_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
